pdu_input_sync: RTL

Front-end conditioner for the PDU's switch/button input path. Synchronises the 16 slide switches and the del/set push-buttons to `clk` and debounces them. Converts each debounced switch toggle into a one-cycle `add` pulse carrying the switch index on `hex`, and each button press into a one-cycle `del`/`set` pulse. Sits directly upstream of the PDU shift register and drives its `hex`/`add`/`del`/`set` inputs.

---
 rtl/pdu_input_sync.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pdu_input_sync.sv
// Switch/button synchroniser, debouncer and event arbiter for the PDU.
// Define PDU_DEBOUNCE_EN to include the debounce counters.
module pdu_input_sync #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_del,
    input  logic        btn_set,
    output logic [3:0]  hex,
    output logic        add,
    output logic        del,
    output logic        set
);

    typedef enum logic {INIT, RUN} state_t;

    state_t      state;
    logic [1:0]  init_cnt;
    logic [17:0] raw;
    logic [17:0] s1;
    logic [17:0] s2;
    logic [17:0] stable;
    logic [17:0] pend;
    logic [17:0] hit;
    logic [17:0] ev;
    logic [17:0] grant;
    logic [3:0]  sel;

    assign raw = {btn_set, btn_del, sw};

`ifdef PDU_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [18];

    always_comb begin
        for (int i = 0; i < 18; i++) begin
            hit[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 18; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 18; i++) begin
                if (state == INIT || s2[i] == stable[i] || hit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign hit = s2 ^ stable;
`endif

    // Buttons only report presses; switches report both directions.
    assign ev = {hit[17:16] & s2[17:16], hit[15:0]};

    always_comb begin
        sel   = '0;
        grant = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) begin
                sel = 4'(i);
            end
        end
        priority case (1'b1)
            pend[17]:       grant[17]  = 1'b1;
            pend[16]:       grant[16]  = 1'b1;
            (|pend[15:0]):  grant[sel] = 1'b1;
            default:        grant      = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            init_cnt <= '0;
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            pend     <= '0;
            hex      <= '0;
            add      <= 1'b0;
            del      <= 1'b0;
            set      <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            add <= 1'b0;
            del <= 1'b0;
            set <= 1'b0;
            if (state == INIT) begin
                stable   <= s2;
                pend     <= '0;
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == 2'd2) begin
                    state <= RUN;
                end
            end else begin
                stable <= stable ^ hit;
                pend   <= (pend & ~grant) | ev;
                set    <= grant[17];
                del    <= grant[16];
                add    <= |grant[15:0];
                if (|grant[15:0]) begin
                    hex <= sel;
                end
            end
        end
    end

endmodule
